mem_responder: RTL and testbench
================================

# mem_responder

Responder end of the single-port memory read interface driven by compute blocks that emit `mem_addr` / `mem_rd_en` and consume `mem_data`. Holds a 2^ADDR_W-entry register-array memory, accepts one read per cycle, and returns data after a fixed, parameterised latency with a companion valid strobe. Also provides a side write port for preload and update. Sits between the compute datapath and the top-level testbench or memory subsystem.

## Interface
- `ADDR_W`, 6, address width; depth = 2^ADDR_W.
- `DATA_W`, 4, data word width.
- `RD_LAT`, 1, read latency in cycles; legal 1..4, elaboration error otherwise.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mem_addr`  in  ADDR_W  read address from initiator.
- `mem_rd_en`  in  1  read request, sampled every rising edge.
- `mem_data`  out  DATA_W  read data returned to initiator.
- `mem_rd_valid`  out  1  high in exactly the cycle `mem_data` carries a response.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `rd_count`  out  8  accepted-read counter, saturates at 255.

## Operation
- Storage: 2^ADDR_W × DATA_W registers; all entries cleared to 0 by reset.
- Read accept: on a rising edge with `mem_rd_en`=1, `mem[mem_addr]` is captured into stage 1 of an RD_LAT-deep data/valid pipeline.
- No backpressure: one read accepted per cycle, unconditionally; full throughput with `mem_rd_en` held high.
- Write: on a rising edge with `wr_en`=1, `mem[wr_addr]` <= `wr_data`.
- Read/write collision (same edge, same address): read-first; the read returns the pre-write value, and the new value is visible to reads on the next edge.
- Read with `mem_rd_en`=0: stage valid is 0 and the data stage holds its previous contents; `mem_data` holds the last returned value when `mem_rd_valid`=0.
- Address arithmetic: full ADDR_W decode and no out-of-range case; the initiator's wrap-around (modulo 2^ADDR_W) is honoured as-is.
- `rd_count`: +1 per accepted read, holds at 255 and never wraps.
- Reset (async, any time): clears memory, pipeline valids and data, `mem_data`=0, `mem_rd_valid`=0, and `rd_count`=0. In-flight reads are discarded and produce no response after reset release.

## Timing
- A request accepted at edge N yields `mem_rd_valid`=1 and `mem_data`=value after edge N+RD_LAT-1; with RD_LAT=1 the result is visible in the cycle immediately after the accept edge.
- Responses are returned in request order, and valid pattern = request pattern delayed by RD_LAT.
- Writes take effect at the edge and are visible to reads accepted at the following edge or later.
- Reset values: `mem_data`=0, `mem_rd_valid`=0, `rd_count`=0.
- First edge after `rst_n` deassertion may accept a read normally.

## Structure
- Shared package `mem_pkg`: `ADDR_W_DEF`=6, `DATA_W_DEF`=4, `RD_LAT_MAX`=4, and typedefs `mem_addr_t` and `mem_data_t`.
- One natural sub-module: `mem_rd_pipe`, the RD_LAT-deep valid+data delay line with async reset. The storage array and counter stay in `mem_responder`.

## Test plan
- Preload: write mem[i]=i mod 16 for i=0..63, then read addr 4,8,12 back-to-back (RD_LAT=1) -> `mem_data` 4,8,12 on consecutive cycles with `mem_rd_valid` high each cycle.
- Collision: mem[20]=3, then on the same edge write 9 to addr 20 and read addr 20 -> response 3; read addr 20 on the next edge -> 9.
- Latency sweep RD_LAT=1..4: single read of addr 63 holding 0xA -> `mem_rd_valid` pulses exactly RD_LAT-1 cycles after the accept cycle, with data 0xA. Idle reads in between hold `mem_data`.
- Wrap: initiator array=60, indvar=0 -> addr (60+4) mod 64 = 0 -> returns mem[0].
- Reset mid-flight (RD_LAT=3): issue reads, then assert `rst_n`=0 for one cycle -> outputs go to 0 immediately, no stale valid after release, and a subsequent read of any addr returns 0.
- Counter: 300 consecutive reads -> `rd_count` reaches 255 and holds; reset -> 0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, latency bound and types for the memory responder slice
package mem_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 4;
  localparam int RD_LAT_MAX = 4;
  typedef logic [ADDR_W_DEF-1:0] mem_addr_t;
  typedef logic [DATA_W_DEF-1:0] mem_data_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: read request/response bus plus side write port and read counter
interface mem_responder_if import mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0] mem_addr, wr_addr;
  logic [DATA_W-1:0] mem_data, wr_data;
  logic mem_rd_en, mem_rd_valid, wr_en;
  logic [7:0] rd_count;
  modport master(output mem_addr, mem_rd_en, wr_en, wr_addr, wr_data,
                 input mem_data, mem_rd_valid, rd_count);
  modport slave(input mem_addr, mem_rd_en, wr_en, wr_addr, wr_data,
                output mem_data, mem_rd_valid, rd_count);
endinterface

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: RD_LAT-deep valid+data delay line; data stages only load behind a valid
module mem_rd_pipe #(
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  logic [RD_LAT-1:0] v;
  logic [DATA_W-1:0] d [RD_LAT];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < RD_LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  assign out_valid = v[RD_LAT-1];
  assign out_data  = d[RD_LAT-1];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: register-array memory answering one read per cycle after RD_LAT cycles
module mem_responder import mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("mem_responder: RD_LAT must be 1..%0d", RD_LAT_MAX);
  end
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.rd_count <= '0;
    else if (bus.mem_rd_en && bus.rd_count != 8'hFF) bus.rd_count <= bus.rd_count + 8'd1;
  // the array read is combinational on the pre-edge contents, which gives read-first on collision
  mem_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.mem_rd_en),
    .in_data  (mem[bus.mem_addr]),
    .out_valid(bus.mem_rd_valid),
    .out_data (bus.mem_data)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: four DUTs (RD_LAT 1..4) on shared stimulus, table vectors plus random vs reference model
module tb_mem_responder;
  import mem_pkg::*;
  logic clk = 0, rst_n = 0;
  logic rd_en = 0, wr_en = 0;
  mem_addr_t addr = '0, wr_addr = '0;
  mem_data_t wr_data = '0;
  mem_data_t o_data [4];
  logic o_valid [4];
  logic [7:0] o_cnt [4];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder_if #(.ADDR_W(6), .DATA_W(4)) bus ();
    assign bus.mem_addr = addr;
    assign bus.mem_rd_en = rd_en;
    assign bus.wr_en = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign o_data[g] = bus.mem_data;
    assign o_valid[g] = bus.mem_rd_valid;
    assign o_cnt[g] = bus.rd_count;
    mem_responder #(.ADDR_W(6), .DATA_W(4), .RD_LAT(g + 1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  end
  int total = 0, bad = 0;
  mem_data_t mm [64];
  bit hist_en [4096];
  mem_data_t hist_d [4096];
  mem_data_t last_ret [4];
  int n = 0, base = 0, cnt = 0;
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic model_clear();
    for (int i = 0; i < 64; i++) mm[i] = '0;
    for (int l = 0; l < 4; l++) last_ret[l] = '0;
    cnt = 0;
    base = n;
  endtask
  // one clock: drive, let the edge happen, advance the model, then compare every latency variant
  task automatic cyc(bit en, int a, bit we = 0, int wa = 0, int wd = 0);
    bit ev;
    rd_en = en; addr = mem_addr_t'(a); wr_en = we; wr_addr = mem_addr_t'(wa); wr_data = mem_data_t'(wd);
    @(posedge clk);
    hist_en[n] = en;
    hist_d[n] = mm[mem_addr_t'(a)];
    if (we) mm[mem_addr_t'(wa)] = mem_data_t'(wd);
    if (en && cnt < 255) cnt++;
    n++;
    #1;
    for (int l = 1; l <= 4; l++) begin
      ev = (n - l >= base) ? hist_en[n - l] : 1'b0;
      if (ev) last_ret[l-1] = hist_d[n - l];
      chk($sformatf("valid_L%0d@%0d", l, n), int'(o_valid[l-1]), int'(ev));
      chk($sformatf("data_L%0d@%0d", l, n), int'(o_data[l-1]), int'(last_ret[l-1]));
      chk($sformatf("count_L%0d@%0d", l, n), int'(o_cnt[l-1]), cnt);
    end
  endtask
  task automatic do_reset(string nm);
    rd_en = 0; wr_en = 0; rst_n = 0;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("%s_valid_L%0d", nm, g + 1), int'(o_valid[g]), 0);
      chk($sformatf("%s_data_L%0d", nm, g + 1), int'(o_data[g]), 0);
      chk($sformatf("%s_count_L%0d", nm, g + 1), int'(o_cnt[g]), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    model_clear();
  endtask
  typedef struct {bit en; int a; bit we; int wa; int wd; bit ev; int ed;} vec_t;
  vec_t tbl [11];
  initial begin
    model_clear();
    #2;
    for (int g = 0; g < 4; g++) begin
      chk("por_valid", int'(o_valid[g]), 0);
      chk("por_data", int'(o_data[g]), 0);
      chk("por_count", int'(o_cnt[g]), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 64; i++) cyc(0, 0, 1, i, i % 16);
    tbl[0]  = '{1, 4, 0, 0, 0, 1, 4};
    tbl[1]  = '{1, 8, 0, 0, 0, 1, 8};
    tbl[2]  = '{1, 12, 0, 0, 0, 1, 12};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 12};
    tbl[4]  = '{0, 0, 1, 20, 3, 0, 12};
    tbl[5]  = '{1, 20, 1, 20, 9, 1, 3};
    tbl[6]  = '{1, 20, 0, 0, 0, 1, 9};
    tbl[7]  = '{0, 0, 1, 63, 10, 0, 9};
    tbl[8]  = '{1, 63, 0, 0, 0, 1, 10};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 10};
    tbl[10] = '{1, (60 + 4) % 64, 0, 0, 0, 1, 0};
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].en, tbl[i].a, tbl[i].we, tbl[i].wa, tbl[i].wd);
      chk($sformatf("tbl%0d_valid", i), int'(o_valid[0]), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), int'(o_data[0]), tbl[i].ed);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0);
    for (int k = 0; k < 5; k++) begin
      if (k == 0) cyc(1, 63); else cyc(0, 0);
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("sweep_L%0d_k%0d_valid", g + 1, k), int'(o_valid[g]), int'(k == g));
        if (k >= g) chk($sformatf("sweep_L%0d_k%0d_data", g + 1, k), int'(o_data[g]), 10);
      end
    end
    for (int i = 0; i < 400; i++) begin
      int a = $urandom_range(0, 63);
      bit coll = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(0, 1) == 1, a, $urandom_range(0, 1) == 1,
          coll ? a : $urandom_range(0, 63), $urandom_range(0, 15));
    end
    for (int i = 0; i < 3; i++) cyc(1, $urandom_range(0, 63));
    do_reset("rst_mid");
    for (int i = 0; i < 5; i++) cyc(0, 0);
    for (int i = 0; i < 8; i++) cyc(1, $urandom_range(0, 63));
    for (int i = 0; i < 300; i++) cyc(1, i % 64);
    chk("cnt_sat", int'(o_cnt[0]), 255);
    do_reset("rst_cnt");
    cyc(1, 5);
    chk("cnt_after_rst", int'(o_cnt[0]), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
